f_pcgen: RTL and testbench
==========================

F_PCGEN -- requirements
Module: f_pcgen

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded into F_valP path after reset.
REQ-002 Parameter PC_STEP, default 4, sequential PC increment in bytes.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 F_valP  input  32  current PC held by the fetch register.
REQ-006 D_stall  input  1  decode cannot accept an instruction this cycle.
REQ-007 br_taken, br_target  input  1, 32  branch redirect request and target.
REQ-008 jmp_valid, jmp_target  input  1, 32  jump redirect request and target.
REQ-009 imem_ready  input  1  instruction memory accepts request this cycle.
REQ-010 imem_valid, imem_rdata  input  1, 32  instruction memory response and data.
REQ-011 f_valP  output  32  next PC presented to the fetch register (combinational).
REQ-012 F_stall  output  1  fetch register hold; 0 = load f_valP this edge (combinational).
REQ-013 imem_req, imem_addr  output  1, 32  memory request and address.
REQ-014 f_instr, f_instr_valid  output  32, 1  fetched instruction to decode (registered).

Function
REQ-015 States SHALL be IDLE, REQ, WAIT, HOLD, encoded in a 2-bit state register.
REQ-016 IDLE: F_stall=1, imem_req=0; next state REQ unconditionally.
REQ-017 REQ: imem_req=1, imem_addr=F_valP, F_stall=1; imem_ready=1 -> WAIT, else stay REQ with request and address held stable.
REQ-018 WAIT: imem_req=0, F_stall=1 until imem_valid; imem_valid ignored in every other state.
REQ-019 WAIT with imem_valid and no redirect (pending or current): f_instr<=imem_rdata, f_instr_valid<=1, -> HOLD.
REQ-020 WAIT with imem_valid and redirect pending or current: response discarded, f_instr_valid stays 0, f_valP=redirect target, F_stall=0, pending cleared, -> REQ.
REQ-021 HOLD: f_instr_valid=1, f_instr stable; redirect present -> f_valP=target, F_stall=0, f_instr_valid<=0, -> REQ.
REQ-022 HOLD, no redirect, D_stall=0: f_valP=F_valP+PC_STEP (mod 2^32), F_stall=0, f_instr_valid<=0, -> REQ.
REQ-023 HOLD, no redirect, D_stall=1: F_stall=1, stay HOLD; f_valP=F_valP+PC_STEP (don't-care for F_reg).
REQ-024 Redirect priority: br_taken over jmp_valid when both asserted same cycle.
REQ-025 Redirect in IDLE, REQ, or WAIT without imem_valid SHALL be stored in a pending register (valid bit + 32-bit target); newer redirect overwrites older.
REQ-026 Current-cycle redirect SHALL take precedence over a stored pending target.
REQ-027 Outside REQ-020/021/022, F_stall SHALL be 1; F_stall=0 for exactly one cycle per PC update.
REQ-028 PC arithmetic SHALL wrap: F_valP=32'hFFFF_FFFC, PC_STEP=4 gives f_valP=32'h0000_0000.
REQ-029 Default f_valP when no update is pending SHALL be F_valP+PC_STEP.

Reset
REQ-030 rst_n=0 at a rising edge: state<=IDLE, f_instr<=0, f_instr_valid<=0, pending valid<=0, pending target<=RESET_PC.
REQ-031 During reset F_stall=1, imem_req=0, f_valP=RESET_PC.
REQ-032 Reset mid-transaction (REQ or WAIT) SHALL abandon the request; a late imem_valid after reset SHALL be ignored (arrives in IDLE/REQ).

Verification
REQ-033 Sequential: F_valP=0x100, imem_ready=1, imem_valid 1 cycle later with 0x2402000A, D_stall=0 -> f_instr=0x2402000A valid one cycle, F_stall=0 with f_valP=0x104.
REQ-034 Decode stall: in HOLD, D_stall=1 for 3 cycles -> F_stall=1, f_instr stable for 3 cycles; release -> f_valP=F_valP+4.
REQ-035 Redirect in flight: br_taken, br_target=0x400 in WAIT before imem_valid -> response dropped, f_instr_valid=0, f_valP=0x400 with F_stall=0 on response cycle.
REQ-036 Priority: br_taken (0x400) and jmp_valid (0x800) in HOLD same cycle -> f_valP=0x400.
REQ-037 Wrap and backpressure: F_valP=0xFFFFFFFC, imem_ready low 2 cycles -> imem_addr held 3 cycles; completion gives f_valP=0x0.
REQ-038 Reset in WAIT, imem_valid the following cycle -> f_instr_valid stays 0, f_valP=RESET_PC, state IDLE then REQ.

Source files
------------

// File: rtl/f_pcgen.sv
`default_nettype none
// ============================================================================
// Module   : f_pcgen
// Purpose  : Fetch-stage next-PC generator and instruction memory sequencer.
// Revision : 1.0
// ============================================================================
module f_pcgen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] F_valP,
  input  logic        D_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_target,
  input  logic        imem_ready,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] f_valP,
  output logic        F_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] f_instr,
  output logic        f_instr_valid
);

  localparam logic [31:0] c_pc_step = 32'(PC_STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_f_instr;
  logic        r_f_instr_valid;
  logic        r_pend_valid;
  logic [31:0] r_pend_tgt;

  logic        w_redir_cur;
  logic [31:0] w_redir_tgt;
  logic        w_redir_any;
  logic [31:0] w_any_tgt;
  logic [31:0] w_seq_pc;
  logic        w_wait_redir;
  logic        w_hold_upd;

  // Branch wins over jump; a live redirect wins over the stored one.
  assign w_redir_cur  = br_taken | jmp_valid;
  assign w_redir_tgt  = br_taken ? br_target : jmp_target;
  assign w_redir_any  = w_redir_cur | r_pend_valid;
  assign w_any_tgt    = w_redir_cur ? w_redir_tgt : r_pend_tgt;
  assign w_seq_pc     = F_valP + c_pc_step;
  assign w_wait_redir = (r_state == S_WAIT) && imem_valid && w_redir_any;
  assign w_hold_upd   = (r_state == S_HOLD) && (w_redir_cur || !D_stall);

  always_comb begin
    f_valP  = w_seq_pc;
    F_stall = 1'b1;
    if (!rst_n) begin
      f_valP = RESET_PC;
    end else if (w_wait_redir) begin
      f_valP  = w_any_tgt;
      F_stall = 1'b0;
    end else if (w_hold_upd) begin
      F_stall = 1'b0;
      if (w_redir_cur) begin
        f_valP = w_redir_tgt;
      end
    end
  end

  assign imem_req      = rst_n && (r_state == S_REQ);
  assign imem_addr     = F_valP;
  assign f_instr       = r_f_instr;
  assign f_instr_valid = r_f_instr_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_f_instr       <= 32'h0;
      r_f_instr_valid <= 1'b0;
      r_pend_valid    <= 1'b0;
      r_pend_tgt      <= RESET_PC;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          if (w_redir_cur) begin
            r_pend_valid <= 1'b1;
            r_pend_tgt   <= w_redir_tgt;
          end
        end
        S_REQ: begin
          if (imem_ready) begin
            r_state <= S_WAIT;
          end
          if (w_redir_cur) begin
            r_pend_valid <= 1'b1;
            r_pend_tgt   <= w_redir_tgt;
          end
        end
        S_WAIT: begin
          if (imem_valid) begin
            if (w_redir_any) begin
              r_state      <= S_REQ;
              r_pend_valid <= 1'b0;
            end else begin
              r_state         <= S_HOLD;
              r_f_instr       <= imem_rdata;
              r_f_instr_valid <= 1'b1;
            end
          end else if (w_redir_cur) begin
            r_pend_valid <= 1'b1;
            r_pend_tgt   <= w_redir_tgt;
          end
        end
        S_HOLD: begin
          if (w_hold_upd) begin
            r_state         <= S_REQ;
            r_f_instr_valid <= 1'b0;
            r_pend_valid    <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_f_pcgen.sv
`default_nettype none
// ============================================================================
// Module   : tb_f_pcgen
// Purpose  : Directed self-checking bench for f_pcgen.
// Revision : 1.0
// ============================================================================
module tb_f_pcgen;

  localparam logic [31:0] c_reset_pc = 32'h0000_1000;

  logic        clk;
  logic        rst_n;
  logic [31:0] F_valP;
  logic        D_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp_valid;
  logic [31:0] jmp_target;
  logic        imem_ready;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] f_valP;
  logic        F_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] f_instr;
  logic        f_instr_valid;

  int checks   = 0;
  int failures = 0;

  f_pcgen #(
    .RESET_PC (c_reset_pc),
    .PC_STEP  (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .F_valP        (F_valP),
    .D_stall       (D_stall),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .jmp_valid     (jmp_valid),
    .jmp_target    (jmp_target),
    .imem_ready    (imem_ready),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .f_valP        (f_valP),
    .F_stall       (F_stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .f_instr       (f_instr),
    .f_instr_valid (f_instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and checks happen mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    F_valP     = 32'h100;
    D_stall    = 1'b0;
    br_taken   = 1'b0;
    br_target  = 32'h0;
    jmp_valid  = 1'b0;
    jmp_target = 32'h0;
    imem_ready = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    #1;
    chk("rst_fstall", {31'h0, F_stall}, 32'd1);
    chk("rst_req", {31'h0, imem_req}, 32'd0);
    chk("rst_fvalp", f_valP, c_reset_pc);
    tick();
    tick();
    chk("rst_ivalid", {31'h0, f_instr_valid}, 32'd0);
    chk("rst_instr", f_instr, 32'h0);

    // Sequential fetch from 0x100
    rst_n = 1'b1;
    #1;
    chk("idle_fstall", {31'h0, F_stall}, 32'd1);
    chk("idle_req", {31'h0, imem_req}, 32'd0);
    chk("idle_fvalp", f_valP, 32'h104);
    tick();
    chk("seq_req", {31'h0, imem_req}, 32'd1);
    chk("seq_addr", imem_addr, 32'h100);
    chk("seq_req_fstall", {31'h0, F_stall}, 32'd1);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    #1;
    chk("seq_wait_req", {31'h0, imem_req}, 32'd0);
    chk("seq_wait_fstall", {31'h0, F_stall}, 32'd1);
    imem_valid = 1'b1;
    imem_rdata = 32'h2402_000A;
    #1;
    chk("seq_resp_fstall", {31'h0, F_stall}, 32'd1);
    tick();
    imem_valid = 1'b0;
    #1;
    chk("seq_instr", f_instr, 32'h2402_000A);
    chk("seq_ivalid", {31'h0, f_instr_valid}, 32'd1);
    chk("seq_hold_fstall", {31'h0, F_stall}, 32'd0);
    chk("seq_hold_fvalp", f_valP, 32'h104);
    tick();
    chk("seq_ivalid_drop", {31'h0, f_instr_valid}, 32'd0);
    chk("seq_back_req", {31'h0, imem_req}, 32'd1);

    // Decode stall holds the instruction for three cycles
    F_valP     = 32'h104;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'h1111_2222;
    tick();
    imem_valid = 1'b0;
    D_stall    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("dstall_fstall", {31'h0, F_stall}, 32'd1);
      chk("dstall_instr", f_instr, 32'h1111_2222);
      chk("dstall_ivalid", {31'h0, f_instr_valid}, 32'd1);
      tick();
    end
    D_stall = 1'b0;
    #1;
    chk("dstall_rel_fstall", {31'h0, F_stall}, 32'd0);
    chk("dstall_rel_fvalp", f_valP, 32'h108);
    tick();

    // Branch arrives while the fetch is in flight
    F_valP     = 32'h108;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    br_taken   = 1'b1;
    br_target  = 32'h400;
    tick();
    br_taken   = 1'b0;
    br_target  = 32'h0;
    #1;
    chk("fly_wait_fstall", {31'h0, F_stall}, 32'd1);
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("fly_resp_fstall", {31'h0, F_stall}, 32'd0);
    chk("fly_resp_fvalp", f_valP, 32'h400);
    tick();
    imem_valid = 1'b0;
    #1;
    chk("fly_ivalid", {31'h0, f_instr_valid}, 32'd0);
    chk("fly_instr_kept", f_instr, 32'h1111_2222);
    chk("fly_back_req", {31'h0, imem_req}, 32'd1);

    // Branch beats jump in HOLD
    F_valP     = 32'h400;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'h3333_4444;
    tick();
    imem_valid = 1'b0;
    D_stall    = 1'b1;
    br_taken   = 1'b1;
    br_target  = 32'h400;
    jmp_valid  = 1'b1;
    jmp_target = 32'h800;
    #1;
    chk("prio_fstall", {31'h0, F_stall}, 32'd0);
    chk("prio_fvalp", f_valP, 32'h400);
    tick();
    br_taken = 1'b0;
    D_stall  = 1'b0;
    #1;
    chk("prio_ivalid", {31'h0, f_instr_valid}, 32'd0);

    // Pending jump from REQ is overridden by a live branch at the response
    tick();
    jmp_valid  = 1'b0;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'h0000_0055;
    br_taken   = 1'b1;
    br_target  = 32'h500;
    #1;
    chk("live_fvalp", f_valP, 32'h500);
    chk("live_fstall", {31'h0, F_stall}, 32'd0);
    tick();
    br_taken   = 1'b0;
    F_valP     = 32'h500;
    imem_valid = 1'b0;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    #1;
    chk("pend_clr_ivalid", {31'h0, f_instr_valid}, 32'd1);
    chk("pend_clr_fvalp", f_valP, 32'h504);
    tick();

    // Wrap-around with two cycles of memory backpressure
    F_valP = 32'hFFFF_FFFC;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_req", {31'h0, imem_req}, 32'd1);
      chk("bp_addr", imem_addr, 32'hFFFF_FFFC);
      if (i == 2) imem_ready = 1'b1;
      tick();
    end
    imem_ready = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'h0000_0066;
    tick();
    imem_valid = 1'b0;
    #1;
    chk("wrap_fstall", {31'h0, F_stall}, 32'd0);
    chk("wrap_fvalp", f_valP, 32'h0);
    tick();

    // Reset while waiting; the late response must be ignored
    F_valP     = 32'h0;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("rw_fvalp", f_valP, c_reset_pc);
    chk("rw_fstall", {31'h0, F_stall}, 32'd1);
    chk("rw_req", {31'h0, imem_req}, 32'd0);
    tick();
    rst_n      = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'h0000_0077;
    #1;
    chk("rw_idle_req", {31'h0, imem_req}, 32'd0);
    chk("rw_idle_fstall", {31'h0, F_stall}, 32'd1);
    chk("rw_instr_clr", f_instr, 32'h0);
    tick();
    imem_valid = 1'b0;
    #1;
    chk("rw_ivalid", {31'h0, f_instr_valid}, 32'd0);
    chk("rw_req_state", {31'h0, imem_req}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
